// File: rtl/dmem_byte_lsu_if.sv
// Bus bundle for dmem_byte_lsu: core request/response channel plus the byte-wide datamem port.
// The slave modport is the LSU itself; master is the core/memory side that surrounds it.
interface dmem_byte_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request handshake: a request transfers on a rising clk edge where req_valid && req_ready.
    // The requester holds all req_* fields stable until that edge. Responses are a single-cycle
    // resp_valid pulse with no back-pressure.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_writedata;
    logic                  mem_memwrite;
    logic [7:0]            mem_readdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_address, mem_writedata, mem_memwrite,
        input  mem_readdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_writedata, mem_memwrite,
        output mem_readdata
    );
endinterface

// File: rtl/dmem_byte_lsu.sv
// Load/store initiator that splits word/half/byte requests into little-endian single-byte datamem cycles.
// Optional MISALIGN_TRAP_EN: reject misaligned half/word requests with resp_err instead of splitting them.
module dmem_byte_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_byte_lsu_if.slave        bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_n;
    logic                  write_q, write_n;
    logic                  uns_q, uns_n;
    logic [1:0]            size_q, size_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [1:0]            idx_q, idx_n;
    logic [1:0]            last_q, last_n;
    logic [DATA_WIDTH-1:0] buf_q, buf_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  err_q, err_n;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_n;
    logic [7:0]            mwdata_q, mwdata_n;
    logic                  mwe_q, mwe_n;
    logic                  misaligned;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [1:0] sz, input logic uns,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        case (sz)
            2'b00:   r = uns ? {24'd0, b[7:0]}   : {{24{b[7]}}, b[7:0]};
            2'b01:   r = uns ? {16'd0, b[15:0]}  : {{16{b[15]}}, b[15:0]};
            default: r = b;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n  = state_q;
        write_n  = write_q;
        uns_n    = uns_q;
        size_n   = size_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        idx_n    = idx_q;
        last_n   = last_q;
        buf_n    = buf_q;
        rdata_n  = rdata_q;
        err_n    = err_q;
        maddr_n  = maddr_q;
        mwdata_n = mwdata_q;
        mwe_n    = mwe_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_n = bus.req_write;
                    uns_n   = bus.req_unsigned;
                    size_n  = bus.req_size;
                    addr_n  = bus.req_addr;
                    wdata_n = bus.req_wdata;
                    idx_n   = 2'd0;
                    buf_n   = '0;
                    case (bus.req_size)
                        2'b01:   last_n = 2'd1;
                        2'b10:   last_n = 2'd3;
                        default: last_n = 2'd0;
                    endcase
                    if ((bus.req_size == 2'b11) || misaligned) begin
                        state_n = S_RESP;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else begin
                        // First memory cycle is presented straight from registers next cycle.
                        state_n  = S_XFER;
                        maddr_n  = bus.req_addr;
                        mwe_n    = bus.req_write;
                        mwdata_n = bus.req_write ? bus.req_wdata[7:0] : 8'd0;
                    end
                end
            end

            S_XFER: begin
                if (!write_q) begin
                    buf_n[{idx_q, 3'b000} +: 8] = bus.mem_readdata;
                end
                if (idx_q == last_q) begin
                    state_n  = S_RESP;
                    maddr_n  = '0;
                    mwdata_n = 8'd0;
                    mwe_n    = 1'b0;
                    err_n    = 1'b0;
                    rdata_n  = write_q ? '0 : extend(size_q, uns_q, buf_n);
                end else begin
                    // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
                    idx_n    = idx_q + 2'd1;
                    maddr_n  = addr_q + ADDR_WIDTH'(idx_n);
                    mwdata_n = write_q ? wdata_q[{idx_n, 3'b000} +: 8] : 8'd0;
                end
            end

            S_RESP: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= 2'd0;
            last_q   <= 2'd0;
            buf_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= 8'd0;
            mwe_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            write_q  <= write_n;
            uns_q    <= uns_n;
            size_q   <= size_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            idx_q    <= idx_n;
            last_q   <= last_n;
            buf_q    <= buf_n;
            rdata_q  <= rdata_n;
            err_q    <= err_n;
            maddr_q  <= maddr_n;
            mwdata_q <= mwdata_n;
            mwe_q    <= mwe_n;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = (state_q == S_RESP);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;
    assign bus.mem_address   = maddr_q;
    assign bus.mem_writedata = mwdata_q;
    assign bus.mem_memwrite  = mwe_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_dmem_byte_lsu.sv
// Directed bench for dmem_byte_lsu: 16x8 memory model, per-cycle bus checks, response scoreboard.
module tb_dmem_byte_lsu;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int cyc;
  int checks;
  int errors;

  logic [32:0] exp_q[$];
  int exp_cyc_q[$];
  logic [7:0] mem [0:15];

  dmem_byte_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_byte_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: async read, sync write
  assign bus.mem_readdata = mem[bus.mem_address[3:0]];
  always @(posedge clk) begin
    if (bus.mem_memwrite) mem[bus.mem_address[3:0]] <= bus.mem_writedata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
      end else begin
        logic [32:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e[32]});
        chk("resp_cycle", cyc, ec);
      end
    end
  end

  // driver
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int acc;
    logic [31:0] wdv;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    wdv = wd;
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid = 1'b0;
    exp_q.push_back({exp_err, exp_rd});
    exp_cyc_q.push_back(exp_err ? acc : acc + n);
    if (exp_err) begin
      @(negedge clk);
      chk("err_no_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
      chk("err_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end else begin
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        chk("xfer_ready_low", {31'd0, bus.req_ready}, 32'd0);
        chk("xfer_memwrite", {31'd0, bus.mem_memwrite}, {31'd0, wr});
        chk("xfer_address", bus.mem_address, a + 32'(k - 1));
        chk("xfer_writedata", {24'd0, bus.mem_writedata}, wr ? {24'd0, wdv[8*(k-1) +: 8]} : 32'd0);
      end
      @(negedge clk);
      chk("resp_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("resp_seen", exp_q.size(), 32'd0);
    chk("idle_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    // reset state
    #12;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_memwrite", {31'd0, bus.mem_memwrite}, 32'd0);
    chk("rst_address", bus.mem_address, 32'd0);
    chk("rst_writedata", {24'd0, bus.mem_writedata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: store word
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, 32'h0, 1'b0);
    chk("t1_mem4", {24'd0, mem[4]}, 32'h44);
    chk("t1_mem5", {24'd0, mem[5]}, 32'h33);
    chk("t1_mem6", {24'd0, mem[6]}, 32'h22);
    chk("t1_mem7", {24'd0, mem[7]}, 32'h11);

    // 2: byte store + signed/unsigned load
    do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h00000080, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 32'h00000080, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_rdata", bus.resp_rdata, 32'h00000080);
    chk("hold_err", {31'd0, bus.resp_err}, 32'd0);

    // 3: half loads
    do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'h00003344, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h8, 32'h0000F00D, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'hFFFFF00D, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'h0000F00D, 1'b0);

    // 4: illegal size
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1);

    // address wrap
`ifdef MISALIGN_TRAP_EN
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 1'b1);
`else
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 1'b0);
    chk("wrap_memF", {24'd0, mem[15]}, 32'hEF);
    chk("wrap_mem0", {24'd0, mem[0]}, 32'hBE);
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0000BEEF, 1'b0);
`endif

    // 5: reset mid-transfer
    do_req(1'b1, 2'b00, 1'b0, 32'hE, 32'h5A, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'hF, 32'hA5, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'hC;
    bus.req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_c3_memwrite", {31'd0, bus.mem_memwrite}, 32'd1);
    chk("t5_c3_address", bus.mem_address, 32'hE);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_memwrite_drop", {31'd0, bus.mem_memwrite}, 32'd0);
    chk("t5_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_memC", {24'd0, mem[12]}, 32'hDD);
    chk("t5_memD", {24'd0, mem[13]}, 32'hCC);
    chk("t5_memE", {24'd0, mem[14]}, 32'h5A);
    chk("t5_memF", {24'd0, mem[15]}, 32'hA5);
    chk("t5_ready_after", {31'd0, bus.req_ready}, 32'd1);

    // 6: misaligned word load
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h01, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h02, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h7, 32'h03, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h8, 32'h04, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 32'h04030201, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
